// File: rtl/y_alu_seq_if.sv
// rtl/y_alu_seq_if.sv - valid/ready operand and result bundle for y_alu_seq
//
// Purpose: carries the issue-side handshake (in_valid/in_ready, a, b, op)
// and the writeback-side handshake (out_valid/out_ready, z, ex).
// Ports (signals):
//   in_valid  master->slave  operands/op presented
//   in_ready  slave->master  block can accept
//   a, b      master->slave  operands, WIDTH bits
//   op        master->slave  3-bit operation select
//   out_valid slave->master  z/ex valid
//   out_ready master->slave  consumer takes result
//   z         slave->master  result, WIDTH bits
//   ex        slave->master  exception flag
interface y_alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             ex;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, z, ex
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, z, ex
  );
endinterface

// File: rtl/y_alu_seq.sv
// rtl/y_alu_seq.sv - handshaked ALU with single-cycle ops and shift-add multiply
//
// Purpose: AND, OR, ADD, SUB, SLT, SLL, SRA complete in one cycle; MUL runs
// WIDTH shift-add iterations. Result and exception flag are registered and
// held until the consumer takes them.
// Ports:
//   clk    input   clock, rising edge
//   rst_n  input   synchronous active-low reset
//   bus    slave   y_alu_seq_if: in_valid/in_ready/a/b/op in,
//                  out_valid/out_ready/z/ex out
module y_alu_seq #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst_n,
  y_alu_seq_if.slave bus
);
  localparam int             SHW  = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] z_q;
  logic             ex_q;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic             ovf;
  logic [SHW-1:0]   count;

  logic             accept;
  logic             out_xfer;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] alu_z;
  logic             alu_ex;
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   step_sum;
  logic             step_ovf;

  // A finished result may be replaced in the same edge it is consumed.
  assign bus.in_ready  = rst_n && ((state == S_IDLE) ||
                                   ((state == S_DONE) && bus.out_ready));
  assign bus.out_valid = (state == S_DONE);
  assign bus.z         = z_q;
  assign bus.ex        = ex_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  // ADD and SUB share one adder; SUB feeds ~b with a carry-in of 1.
  always_comb begin
    addend = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    sum    = bus.a + addend + WIDTH'(bus.op == OP_SUB);
    alu_z  = '0;
    alu_ex = 1'b0;
    case (bus.op)
      OP_AND: alu_z = bus.a & bus.b;
      OP_OR:  alu_z = bus.a | bus.b;
      OP_ADD, OP_SUB: begin
        alu_z  = sum;
        alu_ex = (bus.a[WIDTH-1] == addend[WIDTH-1]) &&
                 (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT: alu_z = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLL: alu_z = bus.a << bus.b[SHW-1:0];
      OP_SRA: alu_z = $unsigned($signed(bus.a) >>> bus.b[SHW-1:0]);
      default: begin
        alu_z  = '0;
        alu_ex = 1'b0;
      end
    endcase
  end

  // One multiply iteration. Overflow is either a carry out of the
  // accumulator or a set multiplicand MSB about to be shifted out while a
  // higher multiplier bit is still pending (that partial product would land
  // at or above bit WIDTH).
  always_comb begin
    mul_addend = mplier[0] ? mcand : '0;
    step_sum   = {1'b0, acc} + {1'b0, mul_addend};
    step_ovf   = step_sum[WIDTH] | (mcand[WIDTH-1] & (|mplier[WIDTH-1:1]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      z_q    <= '0;
      ex_q   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      ovf    <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        S_MUL: begin
          acc    <= step_sum[WIDTH-1:0];
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          ovf    <= ovf | step_ovf;
          count  <= count + SHW'(1);
          if (count == LAST) begin
            z_q   <= step_sum[WIDTH-1:0];
            ex_q  <= ovf | step_ovf;
            state <= S_DONE;
          end
        end
        default: begin
          if (accept) begin
            if (bus.op == OP_MUL) begin
              mcand  <= bus.a;
              mplier <= bus.b;
              acc    <= '0;
              ovf    <= 1'b0;
              count  <= '0;
              state  <= S_MUL;
            end else begin
              z_q   <= alu_z;
              ex_q  <= alu_ex;
              state <= S_DONE;
            end
          end else if (out_xfer || (state != S_DONE)) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_y_alu_seq.sv
// tb/tb_y_alu_seq.sv - self-checking bench for y_alu_seq (WIDTH 32 and 8)
module tb_y_alu_seq;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  y_alu_seq_if #(.WIDTH(32)) bus32 ();
  y_alu_seq_if #(.WIDTH(8))  bus8 ();

  y_alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  y_alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic longint sx(input logic [63:0] x, input int w);
    longint h;
    h = longint'(64'd1 << (w - 1));
    return (longint'(x) ^ h) - h;
  endfunction

  // Arithmetic reference: results from plain integer maths on the operands.
  function automatic void model(input int w, input logic [2:0] op,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] z, output logic ex);
    logic [63:0] m;
    logic [63:0] p;
    longint      sa, sb, s, lim;
    int          sh;
    m   = (64'd1 << w) - 64'd1;
    sa  = sx(a, w);
    sb  = sx(b, w);
    sh  = int'(b & 64'(w - 1));
    lim = longint'(64'd1 << (w - 1));
    z   = 64'd0;
    ex  = 1'b0;
    case (op)
      OP_AND: z = a & b;
      OP_OR:  z = a | b;
      OP_ADD, OP_SUB: begin
        s  = (op == OP_ADD) ? sa + sb : sa - sb;
        z  = $unsigned(s) & m;
        ex = (s >= lim) || (s < -lim);
      end
      OP_SLT: z = (sa < sb) ? 64'd1 : 64'd0;
      OP_SLL: z = (a << sh) & m;
      OP_SRA: z = $unsigned(sa >>> sh) & m;
      default: begin
        p  = a * b;
        z  = p & m;
        ex = (p >> w) != 64'd0;
      end
    endcase
  endfunction

  logic [63:0] q32_z[$];
  logic        q32_ex[$];
  logic [63:0] q8_z[$];
  logic        q8_ex[$];
  int          push32, pop32, push8, pop8;
  bit          hold32, hold8;
  logic [63:0] hz32, hz8;
  logic        hex32, hex8;

  always @(negedge clk) begin : mon32
    logic [63:0] ez;
    logic        eex;
    if (!rst_n) begin
      push32 -= q32_z.size();
      q32_z.delete();
      q32_ex.delete();
      hold32 = 1'b0;
    end else begin
      if (hold32) begin
        check("mon32_hold_valid", 64'(bus32.out_valid), 64'd1);
        check("mon32_hold_z", 64'(bus32.z), hz32);
        check("mon32_hold_ex", 64'(bus32.ex), 64'(hex32));
      end
      hold32 = 1'b0;
      if (bus32.out_valid && bus32.out_ready) begin
        if (q32_z.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL mon32_spurious: result 0x%0h with no pending op", bus32.z);
        end else begin
          check("mon32_z", 64'(bus32.z), q32_z.pop_front());
          check("mon32_ex", 64'(bus32.ex), 64'(q32_ex.pop_front()));
          pop32++;
        end
      end else if (bus32.out_valid) begin
        hold32 = 1'b1;
        hz32   = 64'(bus32.z);
        hex32  = bus32.ex;
      end
      if (bus32.in_valid && bus32.in_ready) begin
        model(32, bus32.op, 64'(bus32.a), 64'(bus32.b), ez, eex);
        q32_z.push_back(ez);
        q32_ex.push_back(eex);
        push32++;
      end
    end
  end

  always @(negedge clk) begin : mon8
    logic [63:0] ez;
    logic        eex;
    if (!rst_n) begin
      push8 -= q8_z.size();
      q8_z.delete();
      q8_ex.delete();
      hold8 = 1'b0;
    end else begin
      if (hold8) begin
        check("mon8_hold_valid", 64'(bus8.out_valid), 64'd1);
        check("mon8_hold_z", 64'(bus8.z), hz8);
        check("mon8_hold_ex", 64'(bus8.ex), 64'(hex8));
      end
      hold8 = 1'b0;
      if (bus8.out_valid && bus8.out_ready) begin
        if (q8_z.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL mon8_spurious: result 0x%0h with no pending op", bus8.z);
        end else begin
          check("mon8_z", 64'(bus8.z), q8_z.pop_front());
          check("mon8_ex", 64'(bus8.ex), 64'(q8_ex.pop_front()));
          pop8++;
        end
      end else if (bus8.out_valid) begin
        hold8 = 1'b1;
        hz8   = 64'(bus8.z);
        hex8  = bus8.ex;
      end
      if (bus8.in_valid && bus8.in_ready) begin
        model(8, bus8.op, 64'(bus8.a), 64'(bus8.b), ez, eex);
        q8_z.push_back(ez);
        q8_ex.push_back(eex);
        push8++;
      end
    end
  end

  // lat counts edges after the accept edge until out_valid is seen.
  task automatic run32(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ez, input logic eex,
                       input int elat);
    int n;
    int lat;
    bit busy_ok;
    n = 0;
    while (!bus32.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    bus32.in_valid = 1'b1;
    bus32.op = op;
    bus32.a  = a;
    bus32.b  = b;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!bus32.out_valid && lat < 100) begin
      if (bus32.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(elat));
    check({name, "_z"}, 64'(bus32.z), 64'(ez));
    check({name, "_ex"}, 64'(bus32.ex), 64'(eex));
    if (elat > 0) check({name, "_busy"}, 64'(busy_ok), 64'd1);
  endtask

  task automatic run8(input string name, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] ez, input logic eex,
                      input int elat);
    int n;
    int lat;
    bit busy_ok;
    n = 0;
    while (!bus8.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    bus8.in_valid = 1'b1;
    bus8.op = op;
    bus8.a  = a;
    bus8.b  = b;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!bus8.out_valid && lat < 100) begin
      if (bus8.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(elat));
    check({name, "_z"}, 64'(bus8.z), 64'(ez));
    check({name, "_ex"}, 64'(bus8.ex), 64'(eex));
    if (elat > 0) check({name, "_busy"}, 64'(busy_ok), 64'd1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [63:0] mz;
    logic        mex;
    bit          stable;
    bit          seen;
    int          accepted;
    int          cyc;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus32.in_valid = 1'b0; bus32.op = 3'b0; bus32.a = '0; bus32.b = '0; bus32.out_ready = 1'b1;
    bus8.in_valid  = 1'b0; bus8.op  = 3'b0; bus8.a  = '0; bus8.b  = '0; bus8.out_ready  = 1'b1;

    // Pin the reference model against hand-computed values.
    model(8, OP_ADD, 64'h7F, 64'h01, mz, mex);
    check("model_add8_z", mz, 64'h80);
    check("model_add8_ex", 64'(mex), 64'd1);
    model(32, OP_SRA, 64'h8000_0000, 64'd4, mz, mex);
    check("model_sra32_z", mz, 64'hF800_0000);
    model(32, OP_MUL, 64'h0001_0000, 64'h0001_0000, mz, mex);
    check("model_mul32_ex", 64'(mex), 64'd1);
    model(32, OP_SUB, 64'h8000_0000, 64'd1, mz, mex);
    check("model_sub32_z", mz, 64'h7FFF_FFFF);
    check("model_sub32_ex", 64'(mex), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    check("rst0_in_ready_low", 64'(bus32.in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst0_out_valid", 64'(bus32.out_valid), 64'd0);
    check("rst0_z", 64'(bus32.z), 64'd0);
    check("rst0_ex", 64'(bus32.ex), 64'd0);
    check("rst0_in_ready", 64'(bus32.in_ready), 64'd1);

    run32("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 0);
    run32("or",  OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 0);
    run32("add", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 0);
    run32("sub", OP_SUB, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 0);
    run32("slt", OP_SLT, 32'hFFFF_FFFD, 32'd2,         32'd1,         1'b0, 0);
    run32("sra", OP_SRA, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 0);
    run32("sll", OP_SLL, 32'd1,         32'd31,        32'h8000_0000, 1'b0, 0);
    run32("mul", OP_MUL, 32'd1234,      32'd5678,      32'd7006652,   1'b0, 32);
    run32("mul_ovf", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0,     1'b1, 32);

    // Back-pressure: ADD result stalls, a waiting OR must not be taken.
    repeat (2) @(posedge clk);
    #1;
    bus32.out_ready = 1'b0;
    bus32.in_valid = 1'b1; bus32.op = OP_ADD; bus32.a = 32'd3; bus32.b = 32'd4;
    @(posedge clk); #1;
    check("bp_valid", 64'(bus32.out_valid), 64'd1);
    bus32.op = OP_OR; bus32.a = 32'd1; bus32.b = 32'd2;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus32.z !== 32'd7 || bus32.ex !== 1'b0 || bus32.out_valid !== 1'b1 ||
          bus32.in_ready !== 1'b0) stable = 1'b0;
    end
    check("bp_stall_stable", 64'(stable), 64'd1);
    bus32.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(bus32.in_ready), 64'd1);
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    check("bp_next_valid", 64'(bus32.out_valid), 64'd1);
    check("bp_next_z", 64'(bus32.z), 64'd3);
    @(posedge clk); #1;
    check("bp_drained", 64'(bus32.out_valid), 64'd0);

    // Reset in the middle of a multiply.
    bus32.in_valid = 1'b1; bus32.op = OP_MUL; bus32.a = 32'd3; bus32.b = 32'd5;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready_low", 64'(bus32.in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_mid_out_valid", 64'(bus32.out_valid), 64'd0);
    check("rst_mid_z", 64'(bus32.z), 64'd0);
    check("rst_mid_ex", 64'(bus32.ex), 64'd0);
    check("rst_mid_in_ready", 64'(bus32.in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus32.out_valid) seen = 1'b1;
    end
    check("rst_mid_no_stale", 64'(seen), 64'd0);

    run8("w8_mul",     OP_MUL, 8'd15,  8'd17, 8'd255,  1'b0, 8);
    run8("w8_mul_ovf", OP_MUL, 8'd16,  8'd16, 8'd0,    1'b1, 8);
    run8("w8_add",     OP_ADD, 8'h7F,  8'h01, 8'h80,   1'b1, 0);
    run8("w8_sra",     OP_SRA, 8'h80,  8'd7,  8'hFF,   1'b0, 0);

    // Random traffic with gated out_ready; the monitor checks every result.
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 60000) begin
      bus32.out_ready = ($urandom_range(0, 3) != 0);
      bus32.in_valid  = ($urandom_range(0, 9) < 7);
      bus32.op        = 3'($urandom_range(0, 7));
      bus32.a         = $urandom >> $urandom_range(0, 31);
      bus32.b         = $urandom >> $urandom_range(0, 31);
      @(negedge clk);
      if (bus32.in_valid && bus32.in_ready) accepted++;
      @(posedge clk); #1;
      cyc++;
    end
    check("rand_accepted", 64'(accepted), 64'd1000);
    bus32.in_valid = 1'b0;
    bus32.out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("rand_pending32", 64'(q32_z.size()), 64'd0);
    check("rand_balance32", 64'(pop32), 64'(push32));
    check("pending8", 64'(q8_z.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
